// File: rtl/tipi_nibble_bus_master.sv
// tipi_nibble_bus_master: arbitrates two requesters onto the 4-bit TIPI Pi bus, one 4-clock transaction each
// Ports: clk/reset (async, active-high); req_valid/req_sel/req_wdata in, req_ready out (2 requesters);
//   rsp_valid/rsp_rdata completion back to the owning requester; bus_clk/bus_reset/bus_data_out/bus_data_oe
//   drive the slave and bus_data_in reads it back; busy is high outside IDLE; tc_value/tc_changed report TC polls.
// Optional: define TIPI_TC_POLL_EN to poll TC automatically after POLL_INTERVAL idle clocks.
module tipi_nibble_bus_master #(
  parameter int CLK_DIV = 4,
  parameter int POLL_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_sel,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        bus_clk,
  output logic        bus_reset,
  output logic [3:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [3:0]  bus_data_in,
  output logic        busy,
  output logic [7:0]  tc_value,
  output logic        tc_changed
);
  typedef enum logic [3:0] {
    RESYNC_A, RESYNC_B, IDLE, P0_LO, P0_HI, P1_LO, P1_HI, P2_LO, P2_HI, P3_LO, P3_HI
  } state_t;
  localparam logic [7:0] LOAD = 8'(CLK_DIV - 1);
  if (CLK_DIV < 1 || CLK_DIV > 255 || POLL_INTERVAL < 1) begin : g_bad_param
    $error("tipi_nibble_bus_master: CLK_DIV must be 1..255 and POLL_INTERVAL >= 1");
  end
  state_t state, state_nx;
  logic [7:0] timer, wdata_q, cap, rdata_q;
  logic [1:0] sel_q;
  logic owner, last, poll, poll_start, adv, fin, rd, g0, g1, grant;
  assign adv = timer == 8'd0;
  assign rd = ~sel_q[1];
  assign fin = state == P3_HI && adv;
  // last-granted requester loses a tie; last resets to 1 so requester 0 wins first
  assign g0 = req_valid[0] & (~req_valid[1] | last);
  assign g1 = req_valid[1] & ~g0;
  assign grant = state == IDLE && (g0 | g1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (grant || poll_start) ? P0_LO : IDLE;
      // a read leaves the slave driving the bus, so it must be reset before the next transaction
      P3_HI:   state_nx = adv ? (rd ? RESYNC_A : IDLE) : P3_HI;
      default: state_nx = adv ? state_t'(state + 4'd1) : state;
    endcase
    bus_clk = state inside {P0_HI, P1_HI, P2_HI, P3_HI};
    bus_reset = state inside {RESYNC_A, RESYNC_B};
    busy = state != IDLE;
    // reads release the bus from P1_LO, before the load-cycle rising edge hands it to the slave
    bus_data_oe = state inside {P0_LO, P0_HI} ||
                  (state inside {P1_LO, P1_HI, P2_LO, P2_HI, P3_LO, P3_HI} && !rd);
    bus_data_out = state inside {P0_LO, P0_HI} ? {2'b00, sel_q} :
                   state inside {P2_LO, P2_HI} && !rd ? wdata_q[7:4] :
                   state inside {P3_LO, P3_HI} && !rd ? wdata_q[3:0] : 4'h0;
    req_ready = grant ? {g1, g0} : 2'b00;
    rsp_valid = fin && !poll ? (owner ? 2'b10 : 2'b01) : 2'b00;
    rsp_rdata = fin && rd && !poll ? cap : rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESYNC_A;
      timer <= LOAD;
      sel_q <= 2'b00;
      wdata_q <= 8'h00;
      cap <= 8'h00;
      rdata_q <= 8'h00;
      owner <= 1'b0;
      last <= 1'b1;
    end else begin
      state <= state_nx;
      timer <= state_nx != state ? LOAD : adv ? timer : timer - 8'd1;
      if (grant) begin
        sel_q <= g1 ? req_sel[3:2] : req_sel[1:0];
        wdata_q <= g1 ? req_wdata[15:8] : req_wdata[7:0];
        owner <= g1;
        last <= g1;
      end else if (poll_start) begin
        sel_q <= 2'b01;
      end
      if (state == P2_LO && adv) cap[7:4] <= bus_data_in;
      if (state == P3_LO && adv) cap[3:0] <= bus_data_in;
      if (fin && rd && !poll) rdata_q <= cap;
    end
  end
`ifdef TIPI_TC_POLL_EN
  logic [15:0] idle_cnt;
  logic [7:0] tc_q;
  logic tc_chg;
  assign poll_start = state == IDLE && req_valid == 2'b00 && idle_cnt == 16'(POLL_INTERVAL - 1);
  assign tc_value = tc_q;
  assign tc_changed = tc_chg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= 16'd0;
      poll <= 1'b0;
      tc_q <= 8'h00;
      tc_chg <= 1'b0;
    end else begin
      idle_cnt <= (req_valid != 2'b00 || poll_start) ? 16'd0 : state == IDLE ? idle_cnt + 16'd1 : idle_cnt;
      poll <= poll_start ? 1'b1 : grant ? 1'b0 : poll;
      tc_chg <= fin && poll && cap != tc_q;
      if (fin && poll) tc_q <= cap;
    end
  end
`else
  assign poll = 1'b0;
  assign poll_start = 1'b0;
  assign tc_value = 8'h00;
  assign tc_changed = 1'b0;
`endif
endmodule

// File: tb/tb_tipi_nibble_bus_master.sv
// tb_tipi_nibble_bus_master: directed bench for tipi_nibble_bus_master with a behavioural TIPI slave
module tb_tipi_nibble_bus_master;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_sel = 4'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, tc_value;
  logic bus_clk, bus_reset, bus_data_oe, busy, tc_changed;
  logic [3:0] bus_data_out, bus_data_in;
  int total = 0, bad = 0;

  tipi_nibble_bus_master #(.CLK_DIV(4), .POLL_INTERVAL(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bus_clk(bus_clk),
    .bus_reset(bus_reset), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_data_in(bus_data_in), .busy(busy), .tc_value(tc_value), .tc_changed(tc_changed)
  );

  always #5 clk = ~clk;

  logic [1:0] k = 2'd0, s_sel = 2'd0;
  logic [3:0] s_hi = 4'h0, s_do = 4'h0;
  logic [3:0] obs [4];
  logic [7:0] s_td = 8'h00, s_tc = 8'h00, s_rd = 8'h00, s_rc = 8'h00, s_val;
  logic s_oe = 1'b0;
  assign s_val = s_sel[0] ? s_tc : s_td;
  assign bus_data_in = s_oe ? s_do : 4'h0;

  always @(posedge bus_clk or posedge bus_reset)
    if (bus_reset) begin
      k <= 2'd0;
      s_oe <= 1'b0;
    end else begin
      obs[k] <= bus_data_out;
      k <= k + 2'd1;
      if (k == 2'd0) s_sel <= bus_data_out[1:0];
      if (k == 2'd1 && !s_sel[1]) begin
        s_oe <= 1'b1;
        s_do <= s_val[7:4];
      end
      if (k == 2'd2) begin
        if (s_sel[1]) s_hi <= bus_data_out;
        else s_do <= s_val[3:0];
      end
      if (k == 2'd3 && s_sel[1]) begin
        if (s_sel[0]) s_rc <= {s_hi, bus_data_out};
        else s_rd <= {s_hi, bus_data_out};
      end
    end

  logic contention = 1'b0, two_ready = 1'b0, oe_rise = 1'b0, pclk = 1'b0, poe = 1'b0;
  always @(negedge clk) begin
    if (bus_data_oe && s_oe) contention <= 1'b1;
    if (req_ready == 2'b11) two_ready <= 1'b1;
    if (!pclk && bus_clk && poe != bus_data_oe) oe_rise <= 1'b1;
    pclk <= bus_clk;
    poe <= bus_data_oe;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic flag;
    repeat (3) cyc();
    chk("rst_bus_reset", bus_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, bus_clk, bus_data_out, bus_data_oe, tc_value, tc_changed}, 0);
    reset = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (bus_reset && n < 50);
    chk("resync_len", n, 8);
    chk("idle_busy", busy, 0);

    req_sel = 4'b0010; req_wdata = 16'h00A5; req_valid = 2'b01; #1;
    chk("wr_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00; n = 1;
    while (rsp_valid == 2'b00 && n < 100) begin cyc(); n++; end
    chk("wr_lat", n, 32);
    chk("wr_rsp", rsp_valid, 2'b01);
    chk("wr_nibbles", {obs[0], obs[1], obs[2], obs[3]}, 16'h20A5);
    cyc();
    chk("wr_slave_rd", s_rd, 8'hA5);
    chk("wr_idle", {busy, bus_data_oe}, 0);

    s_td = 8'h3C; req_sel = 4'b0000; req_valid = 2'b10; #1;
    chk("rd_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00; n = 1; flag = 1'b0;
    while (rsp_valid == 2'b00 && n < 100) begin
      if (n >= 9 && bus_data_oe) flag = 1'b1;
      cyc(); n++;
    end
    chk("rd_lat", n, 32);
    chk("rd_rsp", {rsp_valid, rsp_rdata}, {2'b10, 8'h3C});
    chk("rd_oe_off", flag, 0);
    cyc(); n = 0;
    while (bus_reset && n < 50) begin n++; cyc(); end
    chk("rd_resync", n, 8);
    chk("rd_hold", {busy, rsp_rdata, s_oe}, {1'b0, 8'h3C, 1'b0});

    req_sel = 4'b1110; req_wdata = 16'h2211; req_valid = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 100) begin cyc(); n++; end
      chk("rr_grant", req_ready, i[0] ? 2'b10 : 2'b01);
      cyc();
      if (i == 3) req_valid = 2'b00;
    end
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    chk("rr_regs", {s_rd, s_rc}, 16'h1122);
    chk("rr_single", two_ready, 0);

    req_sel = 4'b0010; req_wdata = 16'h005A; req_valid = 2'b01; #1;
    chk("ab_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    repeat (17) cyc();
    chk("ab_p2", {bus_clk, bus_data_oe, bus_data_out}, {1'b0, 1'b1, 4'h5});
    reset = 1'b1; #1;
    chk("ab_rst", {bus_reset, busy, bus_data_oe}, 3'b110);
    cyc(); reset = 1'b0; n = 0; flag = 1'b0;
    do begin cyc(); n++; if (rsp_valid != 2'b00) flag = 1'b1; end while (bus_reset && n < 50);
    repeat (10) begin cyc(); if (rsp_valid != 2'b00) flag = 1'b1; end
    chk("ab_resync", n, 8);
    chk("ab_no_rsp", flag, 0);
    chk("ab_rd_kept", s_rd, 8'h11);
    chk("ab_rdata_clr", rsp_rdata, 0);

`ifdef TIPI_TC_POLL_EN
    s_tc = 8'h81; n = 0;
    while (!tc_changed && n < 300) begin cyc(); n++; end
    chk("tc_pulse", tc_changed, 1);
    chk("tc_val", tc_value, 8'h81);
    cyc();
    chk("tc_one_clk", tc_changed, 0);
    flag = 1'b0;
    repeat (150) begin
      cyc();
      if (tc_changed || req_ready != 2'b00 || rsp_valid != 2'b00) flag = 1'b1;
    end
    chk("tc_no_repeat", flag, 0);
    chk("tc_hold", tc_value, 8'h81);
`else
    flag = 1'b0;
    repeat (300) begin cyc(); if (tc_changed || busy) flag = 1'b1; end
    chk("no_poll", {flag, tc_value}, 0);
`endif
    chk("no_contention", contention, 0);
    chk("oe_vs_rise", oe_rise, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
